srff_bank: RTL and testbench

Parametrised bank of WIDTH set/reset flip-flop channels sharing one clock and reset. Conflict resolution on simultaneous set and reset is chosen at elaboration time, so the bank never produces X. Adds global enable, synchronous clear, registered edge pulses, a sticky per-channel conflict flag and an optional saturating conflict counter. Used wherever control/status bits are set and cleared by independent event sources, for example interrupt-pending, error-latch and mode bits.

---
 rtl/srff_pkg.sv | 31 +++
 rtl/srff_bank_if.sv | 36 +++
 rtl/srff_cell.sv | 49 ++++
 rtl/srff_bank.sv | 59 +++++
 tb/tb_srff_bank.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/srff_pkg.sv
// Shared types and the per-channel next-state rule for the srff_bank family.
package srff_pkg;

    typedef enum logic [1:0] {
        SRFF_SET_DOM,
        SRFF_RST_DOM,
        SRFF_HOLD,
        SRFF_TOGGLE
    } srff_mode_e;

    // Next state of one enabled channel; a simultaneous set/reset is settled by mode.
    function automatic logic srff_next(logic q, logic s, logic r, srff_mode_e mode);
        logic n;
        n = q;
        case ({s, r})
            2'b00:   n = q;
            2'b01:   n = 1'b0;
            2'b10:   n = 1'b1;
            default: begin
                case (mode)
                    SRFF_SET_DOM: n = 1'b1;
                    SRFF_RST_DOM: n = 1'b0;
                    SRFF_HOLD:    n = q;
                    default:      n = ~q;
                endcase
            end
        endcase
        return n;
    endfunction

endpackage

// File: rtl/srff_bank_if.sv
// Control/status bundle of srff_bank; conflict_cnt exists only with SRFF_BANK_CONFLICT_CNT_EN.
interface srff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             err_clr;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] conflict;
`ifdef SRFF_BANK_CONFLICT_CNT_EN
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output en, clr, err_clr, s, r,
        input  q, rise, fall, conflict, conflict_cnt
    );
    modport slave (
        input  en, clr, err_clr, s, r,
        output q, rise, fall, conflict, conflict_cnt
    );
`else
    modport master (
        output en, clr, err_clr, s, r,
        input  q, rise, fall, conflict
    );
    modport slave (
        input  en, clr, err_clr, s, r,
        output q, rise, fall, conflict
    );
`endif
endinterface

// File: rtl/srff_cell.sv
// One set/reset channel: state, registered edge pulses and sticky conflict flag.
module srff_cell
    import srff_pkg::*;
#(
    parameter srff_mode_e MODE    = SRFF_SET_DOM,
    parameter logic       RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    input  logic err_clr,
    input  logic s,
    input  logic r,
    output logic q,
    output logic rise,
    output logic fall,
    output logic conflict,
    output logic conflict_ev
);

    logic q_next;

    assign conflict_ev = en & ~clr & s & r;

    always_comb begin
        q_next = q;
        if (clr)
            q_next = RST_BIT;
        else if (en)
            q_next = srff_next(q, s, r, MODE);
    end

    // Pulses compare the value about to be loaded with the current one, so they line up with q.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q        <= RST_BIT;
            rise     <= 1'b0;
            fall     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            q        <= q_next;
            rise     <= q_next & ~q;
            fall     <= ~q_next & q;
            conflict <= (conflict & ~err_clr) | conflict_ev;
        end
    end

endmodule

// File: rtl/srff_bank.sv
// Bank of WIDTH set/reset channels; define SRFF_BANK_CONFLICT_CNT_EN for the saturating conflict counter.
module srff_bank
    import srff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter srff_mode_e       MODE    = SRFF_SET_DOM,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rstn,
    srff_bank_if.slave bus
);

    logic [WIDTH-1:0] ev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        srff_cell #(
            .MODE    (MODE),
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk         (clk),
            .rstn        (rstn),
            .en          (bus.en),
            .clr         (bus.clr),
            .err_clr     (bus.err_clr),
            .s           (bus.s[i]),
            .r           (bus.r[i]),
            .q           (bus.q[i]),
            .rise        (bus.rise[i]),
            .fall        (bus.fall[i]),
            .conflict    (bus.conflict[i]),
            .conflict_ev (ev[i])
        );
    end

`ifdef SRFF_BANK_CONFLICT_CNT_EN
    logic             any_ev;
    logic [CNT_W-1:0] cnt;

    assign any_ev = |ev;

    // Counts cycles with any conflict, not conflicting channels; a clear coinciding with an event restarts at 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (bus.err_clr)
            cnt <= {{(CNT_W-1){1'b0}}, any_ev};
        else if (any_ev && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

    assign bus.conflict_cnt = cnt;
`else
    logic unused_ev;
    assign unused_ev = |ev;
`endif

endmodule

// File: tb/tb_srff_bank.sv
// Self-checking bench for srff_bank: one DUT per conflict mode, all driven by the same stimulus.
module tb_srff_bank;
    import srff_pkg::*;

    localparam int         W    = 4;
    localparam logic [3:0] RV   = 4'b1010;
    localparam int         CW   = 2;
    localparam int         CMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en, clr, err_clr;
    logic [3:0] s, r;

    logic [3:0] q_o[4], rise_o[4], fall_o[4], conf_o[4];
`ifdef SRFF_BANK_CONFLICT_CNT_EN
    logic [CW-1:0] cnt_o[4];
`endif

    int checks = 0;
    int failures = 0;

    logic [3:0] mq[4], mr[4], mf[4], mc[4];
    int         mcnt[4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        srff_bank_if #(.WIDTH(W), .CNT_W(CW)) bus ();
        assign bus.en      = en;
        assign bus.clr     = clr;
        assign bus.err_clr = err_clr;
        assign bus.s       = s;
        assign bus.r       = r;
        assign q_o[g]      = bus.q;
        assign rise_o[g]   = bus.rise;
        assign fall_o[g]   = bus.fall;
        assign conf_o[g]   = bus.conflict;
`ifdef SRFF_BANK_CONFLICT_CNT_EN
        assign cnt_o[g]    = bus.conflict_cnt;
`endif
        srff_bank #(
            .WIDTH   (W),
            .MODE    (srff_mode_e'(g)),
            .RST_VAL (RV),
            .CNT_W   (CW)
        ) dut (
            .clk  (clk),
            .rstn (rstn),
            .bus  (bus)
        );
    end

    // Reference: channel outcome written as set/reset equations per mode.
    function automatic logic [3:0] ref_next(int m, logic [3:0] q, logic [3:0] sv, logic [3:0] rv);
        case (m)
            0:       return sv | (q & ~rv);
            1:       return ~rv & (sv | q);
            2:       return (sv & ~rv) | (q & ~(sv ^ rv));
            default: return (sv & ~rv) | (q & ~sv & ~rv) | (~q & sv & rv);
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 4; m++) begin
            mq[m] = RV; mr[m] = '0; mf[m] = '0; mc[m] = '0; mcnt[m] = 0;
        end
    endtask

    task automatic model_edge();
        logic [3:0] nq, ev;
        for (int m = 0; m < 4; m++) begin
            nq = clr ? RV : (en ? ref_next(m, mq[m], s, r) : mq[m]);
            ev = (en && !clr) ? (s & r) : 4'b0000;
            mr[m] = nq & ~mq[m];
            mf[m] = ~nq & mq[m];
            mc[m] = (err_clr ? 4'b0000 : mc[m]) | ev;
            if (err_clr)
                mcnt[m] = (ev != 0) ? 1 : 0;
            else if (ev != 0 && mcnt[m] < CMAX)
                mcnt[m]++;
            mq[m] = nq;
        end
    endtask

    // Advance one clock edge, update the reference, and settle before sampling.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; clr = 1'b0; err_clr = 1'b0; s = '0; r = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        #12;
        model_reset();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if ({q_o[m], rise_o[m], fall_o[m], conf_o[m]} !== {RV, 12'h000}) begin
                failures++;
                $display("FAIL reset_state mode=%0d got q=%b rise=%b fall=%b conf=%b want q=%b rest 0",
                         m, q_o[m], rise_o[m], fall_o[m], conf_o[m], RV);
            end
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int m = 0; m < 4; m++) begin
                checks++;
                if ({q_o[m], rise_o[m], fall_o[m], conf_o[m]} !== {RV, 12'h000}) begin
                    failures++;
                    $display("FAIL reset_hold mode=%0d cyc=%0d got q=%b rise=%b fall=%b conf=%b want q=%b rest 0",
                             m, c, q_o[m], rise_o[m], fall_o[m], conf_o[m], RV);
                end
            end
        end
    endtask

    task automatic test_set_reset();
        logic [3:0] eq[3], er[3], ef[3];
        eq[0] = 4'b0011; er[0] = 4'b0011; ef[0] = 4'b0000;
        eq[1] = 4'b0010; er[1] = 4'b0000; ef[1] = 4'b0001;
        eq[2] = 4'b0010; er[2] = 4'b0000; ef[2] = 4'b0000;
        r = 4'b1111; tick();
        for (int c = 0; c < 3; c++) begin
            s = (c == 0) ? 4'b0011 : 4'b0000;
            r = (c == 1) ? 4'b0001 : 4'b0000;
            tick();
            for (int m = 0; m < 4; m++) begin
                checks++;
                if ({q_o[m], rise_o[m], fall_o[m]} !== {eq[c], er[c], ef[c]}) begin
                    failures++;
                    $display("FAIL set_reset mode=%0d step=%0d got q=%b rise=%b fall=%b want q=%b rise=%b fall=%b",
                             m, c, q_o[m], rise_o[m], fall_o[m], eq[c], er[c], ef[c]);
                end
            end
        end
    endtask

    task automatic test_modes();
        logic [3:0] want;
        r = 4'b1111; tick();
        r = 4'b0000; err_clr = 1'b1; tick();
        err_clr = 1'b0;
        s = 4'b1111; r = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int m = 0; m < 4; m++) begin
                case (m)
                    0:       want = 4'b1111;
                    1, 2:    want = 4'b0000;
                    default: want = (c == 1) ? 4'b0000 : 4'b1111;
                endcase
                checks++;
                if ({q_o[m], conf_o[m]} !== {want, 4'b1111}) begin
                    failures++;
                    $display("FAIL mode_sweep mode=%0d cyc=%0d got q=%b conf=%b want q=%b conf=1111",
                             m, c, q_o[m], conf_o[m], want);
                end
            end
        end
        s = '0; r = '0;
    endtask

    task automatic test_priority();
        r = 4'b1111; tick();
        r = 4'b0000; s = 4'b0101; err_clr = 1'b1; tick();
        err_clr = 1'b0; en = 1'b0; s = 4'b1111; r = 4'b1111; tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if ({q_o[m], conf_o[m]} !== {4'b0101, 4'b0000}) begin
                failures++;
                $display("FAIL prio_en_off mode=%0d got q=%b conf=%b want q=0101 conf=0000", m, q_o[m], conf_o[m]);
            end
        end
        en = 1'b1; clr = 1'b1; r = 4'b0000; tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if ({q_o[m], conf_o[m]} !== {RV, 4'b0000}) begin
                failures++;
                $display("FAIL prio_clr mode=%0d got q=%b conf=%b want q=%b conf=0000", m, q_o[m], conf_o[m], RV);
            end
        end
        clr = 1'b0; s = 4'b1011; r = 4'b1011; tick();
        s = 4'b0100; r = 4'b0100; err_clr = 1'b1; tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (conf_o[m] !== 4'b0100) begin
                failures++;
                $display("FAIL prio_errclr mode=%0d got conf=%b want 0100", m, conf_o[m]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_counter();
`ifdef SRFF_BANK_CONFLICT_CNT_EN
        int want[7];
        want = '{1, 2, 3, 3, 3, 0, 1};
        err_clr = 1'b1; tick();
        for (int c = 0; c < 7; c++) begin
            err_clr = (c >= 5);
            s = (c == 5) ? 4'b0000 : 4'b0001;
            r = s;
            tick();
            for (int m = 0; m < 4; m++) begin
                checks++;
                if (int'(cnt_o[m]) !== want[c]) begin
                    failures++;
                    $display("FAIL counter mode=%0d step=%0d got %0d want %0d", m, c, cnt_o[m], want[c]);
                end
            end
        end
        idle_inputs();
`endif
    endtask

    task automatic test_back_to_back();
        r = 4'b1111; tick();
        for (int c = 0; c < 6; c++) begin
            s = (c % 2 == 0) ? 4'b1111 : 4'b0000;
            r = ~s;
            tick();
            for (int m = 0; m < 4; m++) begin
                checks++;
                if ({q_o[m], rise_o[m], fall_o[m]} !== {s, s, ~s}) begin
                    failures++;
                    $display("FAIL back_to_back mode=%0d cyc=%0d got q=%b rise=%b fall=%b want q=%b rise=%b fall=%b",
                             m, c, q_o[m], rise_o[m], fall_o[m], s, s, ~s);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            en      = ($urandom_range(0, 7) != 0);
            clr     = ($urandom_range(0, 15) == 0);
            err_clr = ($urandom_range(0, 9) == 0);
            s       = 4'($urandom);
            r       = 4'($urandom);
            tick();
            for (int m = 0; m < 4; m++) begin
                checks++;
                if ({q_o[m], rise_o[m], fall_o[m], conf_o[m]} !== {mq[m], mr[m], mf[m], mc[m]}) begin
                    failures++;
                    $display("FAIL random mode=%0d cyc=%0d got q=%b rise=%b fall=%b conf=%b want q=%b rise=%b fall=%b conf=%b",
                             m, c, q_o[m], rise_o[m], fall_o[m], conf_o[m], mq[m], mr[m], mf[m], mc[m]);
                end
`ifdef SRFF_BANK_CONFLICT_CNT_EN
                checks++;
                if (int'(cnt_o[m]) !== mcnt[m]) begin
                    failures++;
                    $display("FAIL random_cnt mode=%0d cyc=%0d got %0d want %0d", m, c, cnt_o[m], mcnt[m]);
                end
`endif
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        s = 4'b1111; r = 4'b1111;
        tick(); tick(); tick();
        #3;
        rstn = 1'b0;
        s = '0; r = '0;
        #1;
        model_reset();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if ({q_o[m], rise_o[m], fall_o[m], conf_o[m]} !== {RV, 12'h000}) begin
                failures++;
                $display("FAIL async_reset mode=%0d got q=%b rise=%b fall=%b conf=%b want q=%b rest 0",
                         m, q_o[m], rise_o[m], fall_o[m], conf_o[m], RV);
            end
`ifdef SRFF_BANK_CONFLICT_CNT_EN
            checks++;
            if (cnt_o[m] !== '0) begin
                failures++;
                $display("FAIL async_reset_cnt mode=%0d got %0d want 0", m, cnt_o[m]);
            end
`endif
        end
        @(negedge clk);
        rstn = 1'b1;
        s = 4'b0110; r = 4'b0110;
        tick();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if ({q_o[m], rise_o[m], fall_o[m], conf_o[m]} !== {mq[m], mr[m], mf[m], mc[m]}) begin
                failures++;
                $display("FAIL post_reset mode=%0d got q=%b rise=%b fall=%b conf=%b want q=%b rise=%b fall=%b conf=%b",
                         m, q_o[m], rise_o[m], fall_o[m], conf_o[m], mq[m], mr[m], mf[m], mc[m]);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_set_reset();
        test_modes();
        test_priority();
        test_counter();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
